// File: rtl/axi_decerr_pkg.sv
// Shared SoC definitions for the AXI decode-error responder.
// Contents:
//   - slave-side ID width, derived from the crossbar master count
//   - DECERR response encoding and the default error data pattern
//   - FSM state encodings for the write and read paths
//   - saturating add used by the error counter
package axi_decerr_pkg;

  localparam int unsigned NumMasters = 2;
  localparam int unsigned MstIdWidth = 4;
  // The crossbar prepends the master index to the ID, so slave IDs are wider.
  localparam int unsigned SlvIdWidth = MstIdWidth + $clog2(NumMasters);

  localparam logic [1:0]  RespDecerr = 2'b11;
  localparam logic [63:0] DecerrData = 64'hBADC_AB1E_BADC_AB1E;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Adds 0..3 to a 32-bit count and clamps at all-ones.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + 33'(inc);
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/axi_decerr_rd_burst.sv
// Read side of the decode-error responder: accepts one AR at a time and
// streams (len+1) R beats, flagging the final one.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   ar_valid_i/ar_ready_o  read address handshake
//   ar_id_i, ar_len_i      ID and burst length minus one
//   r_valid_o/r_ready_i    read data handshake
//   r_id_o, r_last_o       latched ID and last-beat flag
module axi_decerr_rd_burst
  import axi_decerr_pkg::*;
#(
  parameter int unsigned IdWidth = SlvIdWidth
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ar_valid_i,
  output logic               ar_ready_o,
  input  logic [IdWidth-1:0] ar_id_i,
  input  logic [7:0]         ar_len_i,
  output logic               r_valid_o,
  input  logic               r_ready_i,
  output logic [IdWidth-1:0] r_id_o,
  output logic               r_last_o
);

  r_state_e           state_q;
  logic [IdWidth-1:0] id_q;
  // Beats remaining after the one currently presented.
  logic [7:0]         cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= R_IDLE;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (ar_valid_i) begin
            id_q    <= ar_id_i;
            cnt_q   <= ar_len_i;
            state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_ready_i) begin
            if (cnt_q == 8'd0) begin
              state_q <= R_IDLE;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign ar_ready_o = (state_q == R_IDLE);
  assign r_valid_o  = (state_q == R_DATA);
  assign r_last_o   = (state_q == R_DATA) && (cnt_q == 8'd0);
  assign r_id_o     = id_q;

endmodule

// File: rtl/axi_decerr_slave.sv
// AXI4 default slave for unmapped addresses. Every write burst is absorbed
// and answered with DECERR on B; every read burst returns the requested
// number of DECERR beats carrying RespData. A saturating counter and the
// most recent offending address are exposed for debug.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   aw_*                                write address channel
//   w_*                                 write data channel (data discarded)
//   b_*                                 write response channel
//   ar_*                                read address channel
//   r_*                                 read data channel
//   err_count_o                         saturating count of accepted AW+AR
//   last_err_addr_o                     address of most recent accepted error
module axi_decerr_slave
  import axi_decerr_pkg::*;
#(
  parameter int unsigned          IdWidth   = SlvIdWidth,
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter logic [DataWidth-1:0] RespData  = DataWidth'(DecerrData)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic [31:0]          err_count_o,
  output logic [AddrWidth-1:0] last_err_addr_o
);

  // ---------------------------------------------------------------- write
  w_state_e           w_state_q;
  logic [IdWidth-1:0] b_id_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      b_id_q    <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_valid_i) begin
            b_id_q    <= aw_id_i;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_valid_i && w_last_i) w_state_q <= W_RESP;
        end
        W_RESP: begin
          if (b_ready_i) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign aw_ready_o = (w_state_q == W_IDLE);
  assign w_ready_o  = (w_state_q == W_DATA);
  assign b_valid_o  = (w_state_q == W_RESP);
  assign b_id_o     = b_id_q;
  assign b_resp_o   = RespDecerr;

  // ----------------------------------------------------------------- read
  axi_decerr_rd_burst #(
    .IdWidth (IdWidth)
  ) u_rd_burst (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o),
    .ar_id_i    (ar_id_i),
    .ar_len_i   (ar_len_i),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i),
    .r_id_o     (r_id_o),
    .r_last_o   (r_last_o)
  );

  assign r_data_o = RespData;
  assign r_resp_o = RespDecerr;

  // ------------------------------------------------------------ debug info
  logic                 aw_hs;
  logic                 ar_hs;
  logic [31:0]          err_count_q,     err_count_d;
  logic [AddrWidth-1:0] last_err_addr_q, last_err_addr_d;

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign ar_hs = ar_valid_i & ar_ready_o;

  always_comb begin
    err_count_d     = sat_add32(err_count_q, {1'b0, aw_hs} + {1'b0, ar_hs});
    last_err_addr_d = last_err_addr_q;
    // Write address takes priority when both channels handshake together.
    if (aw_hs) begin
      last_err_addr_d = aw_addr_i;
    end else if (ar_hs) begin
      last_err_addr_d = ar_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_count_q     <= '0;
      last_err_addr_q <= '0;
    end else begin
      err_count_q     <= err_count_d;
      last_err_addr_q <= last_err_addr_d;
    end
  end

  assign err_count_o     = err_count_q;
  assign last_err_addr_o = last_err_addr_q;

endmodule

// File: tb/tb_axi_decerr_slave.sv
module tb_axi_decerr_slave;

  localparam logic [63:0] RESP = 64'hBADC_AB1E_BADC_AB1E;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aw_valid = 1'b0;
  logic        aw_ready_o;
  logic [4:0]  aw_id = '0;
  logic [63:0] aw_addr = '0;
  logic        w_valid = 1'b0;
  logic        w_ready_o;
  logic        w_last = 1'b0;
  logic        b_valid_o;
  logic        b_ready = 1'b0;
  logic [4:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid = 1'b0;
  logic        ar_ready_o;
  logic [4:0]  ar_id = '0;
  logic [63:0] ar_addr = '0;
  logic [7:0]  ar_len = '0;
  logic        r_valid_o;
  logic        r_ready = 1'b0;
  logic [4:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic [31:0] err_count_o;
  logic [63:0] last_err_addr_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_decerr_slave dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .aw_valid_i      (aw_valid),
    .aw_ready_o      (aw_ready_o),
    .aw_id_i         (aw_id),
    .aw_addr_i       (aw_addr),
    .w_valid_i       (w_valid),
    .w_ready_o       (w_ready_o),
    .w_last_i        (w_last),
    .b_valid_o       (b_valid_o),
    .b_ready_i       (b_ready),
    .b_id_o          (b_id_o),
    .b_resp_o        (b_resp_o),
    .ar_valid_i      (ar_valid),
    .ar_ready_o      (ar_ready_o),
    .ar_id_i         (ar_id),
    .ar_addr_i       (ar_addr),
    .ar_len_i        (ar_len),
    .r_valid_o       (r_valid_o),
    .r_ready_i       (r_ready),
    .r_id_o          (r_id_o),
    .r_data_o        (r_data_o),
    .r_resp_o        (r_resp_o),
    .r_last_o        (r_last_o),
    .err_count_o     (err_count_o),
    .last_err_addr_o (last_err_addr_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  // Transaction-level view: is a write open, has its data finished,
  // how many read beats remain, and the running totals.
  bit          m_wopen, m_wdone;
  logic [4:0]  m_bid, m_rid;
  int          m_rleft;
  longint      m_cnt;
  logic [63:0] m_addr;
  bit          m_awhs, m_arhs;

  task automatic model_reset();
    m_wopen = 0; m_wdone = 0; m_bid = '0; m_rid = '0;
    m_rleft = 0; m_cnt = 0; m_addr = '0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_awhs = aw_valid && !m_wopen;
      m_arhs = ar_valid && (m_rleft == 0);
      if (m_awhs) begin
        m_wopen = 1; m_wdone = 0; m_bid = aw_id;
      end else if (m_wopen && !m_wdone) begin
        if (w_valid && w_last) m_wdone = 1;
      end else if (m_wopen && m_wdone && b_ready) begin
        m_wopen = 0;
      end
      if (m_rleft > 0) begin
        if (r_ready) m_rleft--;
      end else if (m_arhs) begin
        m_rleft = int'(ar_len) + 1;
        m_rid   = ar_id;
      end
      m_cnt = m_cnt + longint'(m_awhs) + longint'(m_arhs);
      if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
      if (m_awhs) m_addr = aw_addr;
      else if (m_arhs) m_addr = ar_addr;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  task automatic compare();
    chk("aw_ready", 64'(aw_ready_o), 64'(!m_wopen));
    chk("w_ready",  64'(w_ready_o),  64'(m_wopen && !m_wdone));
    chk("b_valid",  64'(b_valid_o),  64'(m_wopen && m_wdone));
    if (m_wopen && m_wdone) chk("b_id", 64'(b_id_o), 64'(m_bid));
    chk("b_resp",   64'(b_resp_o),   64'h3);
    chk("ar_ready", 64'(ar_ready_o), 64'(m_rleft == 0));
    chk("r_valid",  64'(r_valid_o),  64'(m_rleft > 0));
    chk("r_last",   64'(r_last_o),   64'(m_rleft == 1));
    if (m_rleft > 0) chk("r_id", 64'(r_id_o), 64'(m_rid));
    chk("r_data",   r_data_o,        RESP);
    chk("r_resp",   64'(r_resp_o),   64'h3);
    chk("err_count", 64'(err_count_o), 64'(m_cnt));
    chk("last_err_addr", last_err_addr_o, m_addr);
  endtask

  initial forever begin
    @(negedge clk);
    compare();
  end

  // ---------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completes whatever is open on both channels, bounded.
  task automatic drain(input string name);
    bit done = 0;
    aw_valid = 0; ar_valid = 0;
    w_valid = 1; w_last = 1; b_ready = 1; r_ready = 1;
    for (int k = 0; k < 600; k++) begin
      if (aw_ready_o && ar_ready_o) begin
        done = 1;
        break;
      end
      step();
    end
    chk(name, 64'(done), 64'h1);
    w_valid = 0; w_last = 0; b_ready = 0; r_ready = 0;
  endtask

  bit          pat [5] = '{1, 0, 1, 1, 1};
  int          beats, last_at, bcount;
  logic [31:0] cnt0;

  initial begin
    step(); step();
    // reset values
    chk("rst_aw_ready", 64'(aw_ready_o), 64'h1);
    chk("rst_ar_ready", 64'(ar_ready_o), 64'h1);
    chk("rst_r_valid", 64'(r_valid_o), 64'h0);
    chk("rst_b_id", 64'(b_id_o), 64'h0);
    chk("rst_r_id", 64'(r_id_o), 64'h0);
    chk("rst_err_count", 64'(err_count_o), 64'h0);
    rst_n = 1;
    step();

    // single-beat write latency
    aw_valid = 1; aw_id = 5'd5; aw_addr = 64'h5000_0000;
    step();
    aw_valid = 0; w_valid = 1; w_last = 1;
    chk("wr_w_ready_n1", 64'(w_ready_o), 64'h1);
    chk("wr_b_valid_n1", 64'(b_valid_o), 64'h0);
    step();
    w_valid = 0; w_last = 0;
    chk("wr_b_valid_n2", 64'(b_valid_o), 64'h1);
    chk("wr_b_id", 64'(b_id_o), 64'h5);
    chk("wr_b_resp", 64'(b_resp_o), 64'h3);
    chk("wr_err_count", 64'(err_count_o), 64'h1);
    chk("wr_last_addr", last_err_addr_o, 64'h5000_0000);
    step();
    chk("wr_b_hold", 64'(b_valid_o), 64'h1);
    b_ready = 1;
    step();
    b_ready = 0;
    chk("wr_b_done", 64'(b_valid_o), 64'h0);
    chk("wr_aw_ready_back", 64'(aw_ready_o), 64'h1);

    // read len=3 with stalls
    ar_valid = 1; ar_id = 5'd3; ar_addr = 64'h7000_0040; ar_len = 8'd3;
    step();
    ar_valid = 0;
    beats = 0; last_at = -1;
    for (int i = 0; i < 5; i++) begin
      r_ready = pat[i];
      if (r_valid_o && r_ready) begin
        beats++;
        chk("rd_id", 64'(r_id_o), 64'h3);
        chk("rd_data", r_data_o, 64'hBADC_AB1E_BADC_AB1E);
        if (r_last_o) last_at = beats;
      end
      step();
    end
    r_ready = 0;
    chk("rd_beats", 64'(beats), 64'd4);
    chk("rd_last_beat", 64'(last_at), 64'd4);
    chk("rd_idle", 64'(r_valid_o), 64'h0);

    // W beats before AW, then a 16-beat burst
    w_valid = 1; w_last = 0; b_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("early_w_ready", 64'(w_ready_o), 64'h0);
      step();
    end
    aw_valid = 1; aw_id = 5'd7; aw_addr = 64'h9000_1000;
    step();
    aw_valid = 0;
    bcount = 0;
    for (int i = 0; i < 16; i++) begin
      w_last = (i == 15);
      if (b_valid_o) bcount++;
      step();
    end
    w_valid = 0; w_last = 0;
    for (int i = 0; i < 4; i++) begin
      if (b_valid_o) begin
        bcount++;
        chk("burst_b_id", 64'(b_id_o), 64'h7);
      end
      step();
    end
    b_ready = 0;
    chk("burst_b_count", 64'(bcount), 64'd1);

    // simultaneous AW + AR
    cnt0 = err_count_o;
    aw_valid = 1; aw_id = 5'd1; aw_addr = 64'h5000_0000;
    ar_valid = 1; ar_id = 5'd2; ar_addr = 64'h6000_0000; ar_len = 8'd0;
    step();
    aw_valid = 0; ar_valid = 0;
    chk("both_count", 64'(err_count_o), 64'(cnt0) + 64'd2);
    chk("both_addr", last_err_addr_o, 64'h5000_0000);
    drain("both_drain");

    // saturation
    force dut.err_count_q = 32'hFFFF_FFFE;
    m_cnt = 64'hFFFF_FFFE;
    step();
    release dut.err_count_q;
    aw_valid = 1; aw_id = 5'd4; aw_addr = 64'hA000_0000;
    ar_valid = 1; ar_id = 5'd6; ar_addr = 64'hB000_0000; ar_len = 8'd1;
    step();
    aw_valid = 0; ar_valid = 0;
    chk("sat_count", 64'(err_count_o), 64'hFFFF_FFFF);
    drain("sat_drain1");
    ar_valid = 1; ar_id = 5'd8; ar_addr = 64'hC000_0000; ar_len = 8'd0;
    step();
    ar_valid = 0;
    chk("sat_hold", 64'(err_count_o), 64'hFFFF_FFFF);
    chk("sat_addr", last_err_addr_o, 64'hC000_0000);
    drain("sat_drain2");

    // reset during beat 2 of a len=7 read
    ar_valid = 1; ar_id = 5'd10; ar_addr = 64'hD000_0000; ar_len = 8'd7;
    step();
    ar_valid = 0; r_ready = 1;
    step();
    chk("mid_r_valid", 64'(r_valid_o), 64'h1);
    rst_n = 0;
    #1;
    chk("mid_rst_r_valid", 64'(r_valid_o), 64'h0);
    chk("mid_rst_ar_ready", 64'(ar_ready_o), 64'h1);
    chk("mid_rst_count", 64'(err_count_o), 64'h0);
    r_ready = 0;
    step();
    rst_n = 1;
    step();
    ar_valid = 1; ar_id = 5'd12; ar_addr = 64'hE000_0000; ar_len = 8'd0;
    step();
    ar_valid = 0;
    chk("post_r_valid", 64'(r_valid_o), 64'h1);
    chk("post_r_last", 64'(r_last_o), 64'h1);
    chk("post_r_id", 64'(r_id_o), 64'd12);
    r_ready = 1;
    step();
    r_ready = 0;
    chk("post_r_done", 64'(r_valid_o), 64'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
